// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and word geometry for the instruction loader
package loader_pkg;
  typedef enum logic [2:0] {COUNT, DATA, CHECK, DONE, ERR} state_e;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/word_packer.sv
// word_packer: big-endian byte-to-word assembly with running XOR checksum
module word_packer
  import loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [7:0]        din,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic [7:0]        csum
);
  localparam int SW = DATA_W - 8;
  localparam int IW = $clog2(BYTES_PER_WORD);
  logic [SW-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  assign word = {shift_q, din};
  assign word_valid = push && idx_q == IW'(BYTES_PER_WORD - 1);
  assign csum = csum_q;
  // shift in bytes MSB-first, count them and fold them into the checksum
  always_comb begin
    shift_d = clr ? '0 : push ? word[SW-1:0] : shift_q;
    idx_d   = clr ? '0 : push ? idx_q + 1'b1 : idx_q;
    csum_d  = clr ? '0 : push ? csum_q ^ din : csum_q;
  end
  // assembly registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: writes a framed, checksummed program into instruction memory and holds the CPU until it is verified
module instr_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W      = 7,
  parameter int          DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_last_q, n_last_d, word_idx_q, word_idx_d, addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, word;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic              we_q, we_d, rx_ready_q, cpu_hold_q, done_q, err_q;
  logic              hs, last_wr, tmo_hit, push, clr, word_valid;
  logic [7:0]        csum;
  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .din(rx_data),
    .word(word), .word_valid(word_valid), .csum(csum)
  );
  assign hs      = rx_valid && rx_ready_q;
  assign last_wr = we_q && word_idx_q == n_last_q;
  assign tmo_inc = tmo_q + 1'b1;
  assign tmo_hit = TIMEOUT_CYC != 0 && !hs && tmo_inc == TW'(TIMEOUT_CYC);
  // next state, packer control and memory-write staging; a byte arriving in the
  // final write cycle is already the checksum, so it is compared there directly
  always_comb begin
    state_d    = state_q;
    n_last_d   = n_last_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    tmo_d      = '0;
    push       = 1'b0;
    clr        = 1'b0;
    case (state_q)
      COUNT: if (hs) begin
        n_last_d   = ADDR_W'(rx_data - 8'd1);
        word_idx_d = '0;
        clr        = 1'b1;
        state_d    = DATA;
      end
      DATA: begin
        tmo_d      = hs ? '0 : tmo_inc;
        word_idx_d = we_q ? word_idx_q + 1'b1 : word_idx_q;
        if (last_wr) state_d = hs ? (rx_data == csum ? DONE : ERR) : CHECK;
        else if (hs) begin
          push    = 1'b1;
          we_d    = word_valid;
          addr_d  = word_valid ? word_idx_q : addr_q;
          wdata_d = word_valid ? word : wdata_q;
        end
        if (tmo_hit) state_d = ERR;
      end
      CHECK: begin
        tmo_d = hs ? '0 : tmo_inc;
        if (hs) state_d = rx_data == csum ? DONE : ERR;
        else if (tmo_hit) state_d = ERR;
      end
      default: ;
    endcase
    if (start) begin
      state_d    = COUNT;
      word_idx_d = '0;
      we_d       = 1'b0;
      tmo_d      = '0;
      push       = 1'b0;
      clr        = 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COUNT;
      n_last_q   <= '0;
      word_idx_q <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_last_q   <= n_last_d;
      word_idx_q <= word_idx_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= state_d inside {COUNT, DATA, CHECK};
      cpu_hold_q <= state_d != DONE;
      done_q     <= state_d == DONE;
      err_q      <= state_d == ERR;
    end
  end
  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed scenarios for the instruction loader
module tb_instr_loader;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, imem_we, cpu_hold, done, err;
  logic [6:0]  imem_addr;
  logic [31:0] imem_wdata;
  int          vectors = 0, miscompares = 0;
  logic [6:0]  log_a[$];
  logic [31:0] log_d[$];
  logic [31:0] exp_w[2] = '{32'h20010005, 32'h0000002A};
  logic [7:0]  pay[8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h2A};

  instr_loader #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // every write strobe observed, in order
  always @(negedge clk) if (imem_we) begin
    log_a.push_back(imem_addr);
    log_d.push_back(imem_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit got = 1'b0;
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!got && t < 64) begin
      got = rx_ready;
      tick();
      t++;
    end
    rx_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL handshake byte %h: rx_ready stayed %b, required 1", b, rx_ready);
    end
    if (gap) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] ck, input bit gap);
    send_byte(8'h02, gap);
    for (int i = 0; i < 8; i++) send_byte(pay[i], gap);
    send_byte(ck, gap);
  endtask

  task automatic test_reset();
    tick();
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b00100 || imem_addr !== 7'd0 || imem_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy/we/hold/done/err=%b addr=%h wdata=%h, required 00100 0 0",
               {rx_ready, imem_we, cpu_hold, done, err}, imem_addr, imem_wdata);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b10100) begin
      miscompares++;
      $display("FAIL reset_release: got %b, required 10100", {rx_ready, imem_we, cpu_hold, done, err});
    end
  endtask

  task automatic test_load(input bit gap);
    int base;
    pulse_start();
    base = log_a.size();
    send_frame(8'h0E, gap);
    tick();
    tick();
    vectors++;
    if (log_a.size() - base !== 2) begin
      miscompares++;
      $display("FAIL load_writes gap=%0d: got %0d writes, required 2", gap, log_a.size() - base);
    end else for (int i = 0; i < 2; i++) begin
      vectors++;
      if (log_a[base+i] !== 7'(i) || log_d[base+i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL load_word%0d gap=%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                 i, gap, log_a[base+i], log_d[base+i], i, exp_w[i]);
      end
    end
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b00010) begin
      miscompares++;
      $display("FAIL load_done gap=%0d: got %b, required 00010", gap, {rx_ready, imem_we, cpu_hold, done, err});
    end
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    repeat (3) tick();
    rx_valid = 1'b0;
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b00010 || log_a.size() - base !== 2) begin
      miscompares++;
      $display("FAIL done_ignores_bytes: got %b writes=%0d, required 00010 writes=2",
               {rx_ready, imem_we, cpu_hold, done, err}, log_a.size() - base);
    end
  endtask

  task automatic test_bad_checksum();
    int base;
    pulse_start();
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b10100) begin
      miscompares++;
      $display("FAIL start_clears_done: got %b, required 10100", {rx_ready, imem_we, cpu_hold, done, err});
    end
    base = log_a.size();
    send_frame(8'h0F, 1'b0);
    tick();
    tick();
    vectors++;
    if (log_a.size() - base !== 2 || {rx_ready, imem_we, cpu_hold, done, err} !== 5'b00101) begin
      miscompares++;
      $display("FAIL bad_checksum: got writes=%0d status=%b, required writes=2 status=00101",
               log_a.size() - base, {rx_ready, imem_we, cpu_hold, done, err});
    end
  endtask

  task automatic test_full_capacity();
    int base;
    logic [7:0] ck = 8'h00;
    logic [31:0] w;
    pulse_start();
    base = log_a.size();
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 512; i++) begin
      ck ^= 8'(i);
      send_byte(8'(i), 1'b0);
    end
    send_byte(ck, 1'b0);
    tick();
    tick();
    vectors++;
    if (log_a.size() - base !== 128) begin
      miscompares++;
      $display("FAIL n0_writes: got %0d writes, required 128", log_a.size() - base);
    end else begin
      for (int i = 0; i < 128; i++) begin
        w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        vectors++;
        if (log_a[base+i] !== 7'(i) || log_d[base+i] !== w) begin
          miscompares++;
          $display("FAIL n0_word%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                   i, log_a[base+i], log_d[base+i], i, w);
        end
      end
      vectors++;
      if (log_a[base+127] !== 7'd127) begin
        miscompares++;
        $display("FAIL n0_last_addr: got %0d, required 127", log_a[base+127]);
      end
    end
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b00010) begin
      miscompares++;
      $display("FAIL n0_done: got %b, required 00010", {rx_ready, imem_we, cpu_hold, done, err});
    end
  endtask

  task automatic test_timeout();
    int base;
    pulse_start();
    base = log_a.size();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(pay[i], 1'b0);
    repeat (15) tick();
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b10100) begin
      miscompares++;
      $display("FAIL timeout_early: after 15 idle cycles got %b, required 10100", {rx_ready, imem_we, cpu_hold, done, err});
    end
    tick();
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b00101) begin
      miscompares++;
      $display("FAIL timeout_hit: after 16 idle cycles got %b, required 00101", {rx_ready, imem_we, cpu_hold, done, err});
    end
    repeat (4) tick();
    vectors++;
    if (log_a.size() - base !== 0) begin
      miscompares++;
      $display("FAIL timeout_writes: got %0d writes, required 0", log_a.size() - base);
    end
  endtask

  task automatic test_restart();
    int base;
    pulse_start();
    base = log_a.size();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b0);
    rx_data  = pay[5];
    rx_valid = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b10100) begin
      miscompares++;
      $display("FAIL restart_state: got %b, required 10100", {rx_ready, imem_we, cpu_hold, done, err});
    end
    vectors++;
    if (log_a.size() - base !== 1 || log_d[log_d.size()-1] !== exp_w[0]) begin
      miscompares++;
      $display("FAIL restart_partial: got writes=%0d last=%h, required writes=1 last=%h",
               log_a.size() - base, log_d[log_d.size()-1], exp_w[0]);
    end
    test_load(1'b0);
  endtask

  task automatic test_rst_mid_load();
    pulse_start();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b0);
    rst = 1'b1;
    tick();
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b00100 || imem_addr !== 7'd0 || imem_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got %b addr=%h wdata=%h, required 00100 0 0",
               {rx_ready, imem_we, cpu_hold, done, err}, imem_addr, imem_wdata);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({rx_ready, imem_we, cpu_hold, done, err} !== 5'b10100) begin
      miscompares++;
      $display("FAIL rst_mid_ready: got %b, required 10100", {rx_ready, imem_we, cpu_hold, done, err});
    end
  endtask

  initial begin
    test_reset();
    test_load(1'b0);
    test_bad_checksum();
    test_full_capacity();
    test_load(1'b1);
    test_timeout();
    test_restart();
    test_rst_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer-side counterpart to the CPU's instruction-memory read port.
- Accepts a framed byte stream (count, payload, checksum) from a host-link receiver.
- Packs payload bytes into 32-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU pipeline (PC, IF/ID) in reset until a verified program is resident.

Parameters:
- ADDR_W, 7: instruction-memory word-address width; capacity 2^ADDR_W words (matches PC width).
- DATA_W, 32: instruction word width; fixed at 4 bytes.
- TIMEOUT_CYC, 1000000: max cycles between accepted bytes in DATA/CHECK; 0 disables timeout.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; re-arms loader (see Behaviour).
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  DATA_W  write word.
- cpu_hold  out  1  1 = CPU held in reset.
- done  out  1  program loaded and checksum verified.
- err  out  1  checksum mismatch or timeout.

Behaviour:
- All outputs are registered.
- States: COUNT, DATA, CHECK, DONE, ERR.
- Reset:
  - State = COUNT.
  - rx_ready=0 on the reset cycle, 1 thereafter while in COUNT.
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0.
  - Word/byte counters, checksum and timeout counter cleared.
- COUNT:
  - rx_ready=1.
  - On handshake, latch N = rx_data; N=0 means 2^ADDR_W words.
  - Clear word_idx, byte_idx and csum; go to DATA.
  - No timeout in this state.
- DATA:
  - rx_ready=1.
  - Each handshake shifts the byte into an assembly register, big-endian: first byte goes to bits 31:24.
  - Each handshake updates csum ^= byte and increments byte_idx mod 4.
  - On the 4th byte: the next cycle presents imem_we=1, imem_addr=word_idx and imem_wdata=assembled word, then word_idx increments.
  - Write output registers are separate from the assembly register, so back-to-back bytes at full rate are legal; rx_ready never drops in DATA.
  - After the write of word N-1, go to CHECK.
- CHECK:
  - rx_ready=1; the next byte is the checksum.
  - If equal to csum: go to DONE.
  - Otherwise: go to ERR.
- DONE:
  - done=1, cpu_hold=0, rx_ready=0.
  - Incoming bytes are ignored (not consumed).
- ERR:
  - err=1, cpu_hold=1, rx_ready=0.
- Timeout:
  - In DATA/CHECK, a counter increments on every cycle without a handshake and clears on each handshake.
  - When it reaches TIMEOUT_CYC: go to ERR.
- start:
  - In any state, the next state is COUNT.
  - Clears done, err and counters; sets cpu_hold=1.
  - Any imem_we pulse due that cycle is suppressed.
  - start has priority over a simultaneous handshake; that byte is dropped.
- Partial loads (ERR, start, or rst mid-load): words already written stay in memory; the loader does not erase them.
- imem_we is never asserted outside DATA, including the final word's write cycle.
- Address wrap: word_idx never exceeds N-1 ≤ 2^ADDR_W-1, so no write wraps past capacity.

Decomposition:
- Shared package `loader_pkg`: state enum (COUNT, DATA, CHECK, DONE, ERR) and the byte-per-word constant (4).
- One natural sub-module, `word_packer`: 8→32 big-endian shift register with byte counter, a word_valid pulse and checksum accumulation.
- FSM, timeout counter and memory-write registers stay in instr_loader.

Test Plan:
- Nominal load:
  - Stimulus: N=2, bytes 20 01 00 05, 00 00 00 2A, checksum 0x0E (XOR of all 8 payload bytes), full-rate valid.
  - Response: writes addr0=0x20010005 and addr1=0x0000002A, one cycle each; then done=1, cpu_hold=0.
- Bad checksum:
  - Stimulus: same stream with checksum 0x0F.
  - Response: both words still written; err=1, cpu_hold=1, rx_ready=0.
- N=0:
  - Stimulus: 512 payload bytes.
  - Response: 128 writes, addresses 0..127 in order, last imem_addr=127; correct checksum → done.
- Gapped stream:
  - Stimulus: rx_valid toggled 1/0 every cycle.
  - Response: same words as the nominal load, no duplicate or skipped writes.
  - With TIMEOUT_CYC=16: a 16-cycle stall after byte 3 → err=1 exactly on the 16th idle cycle; no further writes.
- Mid-load restart:
  - Stimulus: start pulse coincident with byte 6 of a load.
  - Response: byte dropped, state COUNT, cpu_hold=1, done=err=0.
  - A subsequent complete frame loads correctly from addr0.
- Reset mid-load:
  - Stimulus: rst during DATA.
  - Response: next cycle all outputs at reset values; rx_ready=1 one cycle later.
